// File: rtl/vga_timing_pkg.sv
// Mode constants shared by the 640x480 VGA generator and capture blocks,
// plus the capture FSM encoding and the colour-bar palette.
package vga_timing_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 655;
  localparam int H_SYNC_END   = 750;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 489;
  localparam int V_SYNC_END   = 490;
  localparam int V_TOTAL      = 521;
  localparam int PIX_DELAY    = 1;
  localparam int LOCK_FRAMES  = 2;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    H_ALIGNED = 2'd1,
    LOCKING   = 2'd2,
    LOCKED    = 2'd3
  } cap_state_e;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_RED    = 12'hf00;
  localparam logic [11:0] COL_ORANGE = 12'hf80;
  localparam logic [11:0] COL_GREEN  = 12'h0f0;
  localparam logic [11:0] COL_PURPLE = 12'h808;
endpackage

// File: rtl/vga_capture_sync_edge_det.sv
// Registers one active-low sync pin and flags falling/rising edges of the
// registered sample against the sample one cycle older.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);
  logic cur, prev;

  // Idle level of a sync line is high, so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign fall = ~cur & prev;
  assign rise = cur & ~prev;
endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers (x, y) from the sync edges, polices sync timing
// against the mode and emits a qualified pixel stream once locked.
module vga_capture #(
  parameter int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC_START = vga_timing_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
  parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC_START = vga_timing_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int PIX_DELAY    = vga_timing_pkg::PIX_DELAY,
  parameter int LOCK_FRAMES  = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  vid_r,
  input  logic [3:0]  vid_g,
  input  logic [3:0]  vid_b,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        h_err,
  output logic        v_err
);
  import vga_timing_pkg::*;

  localparam logic [9:0]  HA  = 10'(H_ACTIVE);
  localparam logic [9:0]  HSS = 10'(H_SYNC_START);
  localparam logic [9:0]  HSR = 10'(H_SYNC_END + 1);
  localparam logic [9:0]  HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VA  = 10'(V_ACTIVE);
  localparam logic [9:0]  VSS = 10'(V_SYNC_START);
  localparam logic [9:0]  VSR = 10'(V_SYNC_END + 1);
  localparam logic [9:0]  VT1 = 10'(V_TOTAL - 1);
  localparam logic [10:0] PD  = 11'(PIX_DELAY);
  localparam logic [3:0]  LF1 = 4'(LOCK_FRAMES - 1);

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [11:0] rgb_q;

  sync_edge_det u_hs (.clk(clk), .rst(rst), .din(vid_hsync), .fall(hs_fall), .rise(hs_rise));
  sync_edge_det u_vs (.clk(clk), .rst(rst), .din(vid_vsync), .fall(vs_fall), .rise(vs_rise));

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= 12'h000;
    else     rgb_q <= {vid_r, vid_g, vid_b};
  end

  cap_state_e  state, state_nxt;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  good_cnt;
  logic        h_bad, v_bad, err, h_end, frame_end;
  logic [10:0] hd;
  logic [9:0]  hp;
  logic        vld_nxt;

  assign h_end     = (h_cnt == HT1);
  assign frame_end = h_end && (v_cnt == VT1);
  assign err       = h_bad | v_bad;

  // Signed-safe pixel column: bit 10 set means h_cnt < PIX_DELAY.
  assign hd      = {1'b0, h_cnt} - PD;
  assign hp      = hd[9:0];
  assign vld_nxt = (state == LOCKED) && !err && !hd[10] && (hp < HA) && (v_cnt < VA);

  always_comb begin
    h_bad = 1'b0;
    if (state != UNLOCKED) begin
      if (h_cnt == HSS)      h_bad = ~hs_fall;
      else if (h_cnt == HSR) h_bad = ~hs_rise;
      else                   h_bad = hs_fall | hs_rise;
    end
  end

  always_comb begin
    v_bad = 1'b0;
    if (state == LOCKING || state == LOCKED) begin
      if (h_cnt != 10'd0)    v_bad = vs_fall | vs_rise;
      else if (v_cnt == VSS) v_bad = ~vs_fall;
      else if (v_cnt == VSR) v_bad = ~vs_rise;
      else                   v_bad = vs_fall | vs_rise;
    end
  end

  // Errors win over any forward transition.
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED:  if (hs_fall) state_nxt = H_ALIGNED;
      H_ALIGNED: if (err) state_nxt = UNLOCKED;
                 else if (vs_fall && h_cnt == 10'd0) state_nxt = LOCKING;
      LOCKING:   if (err) state_nxt = UNLOCKED;
                 else if (frame_end && good_cnt == LF1) state_nxt = LOCKED;
      LOCKED:    if (err) state_nxt = UNLOCKED;
      default:   state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      h_cnt    <= 10'd0;
      v_cnt    <= 10'd0;
      good_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == UNLOCKED && hs_fall) h_cnt <= HSS + 10'd1;
      else if (h_end)                   h_cnt <= 10'd0;
      else                              h_cnt <= h_cnt + 10'd1;
      // The vs fall sample is h=0 of line V_SYNC_START, so the next pixel is h=1 of that line.
      if (state == H_ALIGNED && state_nxt == LOCKING) begin
        v_cnt    <= VSS;
        good_cnt <= 4'd0;
      end else begin
        if (h_end) v_cnt <= (v_cnt == VT1) ? 10'd0 : v_cnt + 10'd1;
        if (state == LOCKING && frame_end) good_cnt <= good_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      pix_rgb   <= 12'h000;
      sof       <= 1'b0;
      eol       <= 1'b0;
      locked    <= 1'b0;
      h_err     <= 1'b0;
      v_err     <= 1'b0;
    end else begin
      pix_valid <= vld_nxt;
      pix_x     <= hp;
      pix_y     <= v_cnt;
      pix_rgb   <= rgb_q;
      sof       <= vld_nxt && (hp == 10'd0) && (v_cnt == 10'd0);
      eol       <= vld_nxt && (hp == HA - 10'd1);
      locked    <= (state_nxt == LOCKED);
      h_err     <= h_bad;
      v_err     <= v_bad;
    end
  end
endmodule
